register_writeback: RTL and testbench

REGISTER_WRITEBACK -- requirements
Module: register_writeback

---
 rtl/register_writeback.sv | 135 +++++++++++++
 tb/tb_register_writeback.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback.sv
// Register-file writeback stage: merges never-stalled ALU results with buffered load
// results and keeps a pending-load scoreboard for operand hazard lookups.
module register_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        aluValid,
    input  logic [4:0]  aluRd,
    input  logic [31:0] aluData,
    input  logic        loadIssue,
    input  logic [4:0]  loadIssueRd,
    input  logic        loadValid,
    input  logic [4:0]  loadRd,
    input  logic [31:0] loadData,
    output logic        loadReady,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1Busy,
    output logic        rs2Busy,
    output logic        writeRegister,
    output logic [4:0]  rd,
    output logic [31:0] dataToWrite
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic             write_q, write_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;

    logic             push;
    logic             pop;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;

    // Ready depends on registered occupancy only, so no loadValid->loadReady path.
    assign loadReady = (count_q < CNT_FULL);
    assign push      = loadValid && loadReady;
    assign pop       = !aluValid && (count_q != '0);
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = loadRd;
            fifo_data_d[wr_ptr_q] = loadData;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // A new issue to the same register outlives the pop of the older load.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (loadIssue && (loadIssueRd != 5'd0)) begin
            pending_d[loadIssueRd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        write_d = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        if (aluValid) begin
            write_d = (aluRd != 5'd0);
            rd_d    = aluRd;
            data_d  = aluData;
        end else if (pop) begin
            write_d = (head_rd != 5'd0);
            rd_d    = head_rd;
            data_d  = head_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            write_q   <= 1'b0;
            rd_q      <= 5'd0;
            data_q    <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            write_q   <= write_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    // Buffer storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clock) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign rs1Busy       = (rs1 != 5'd0) && pending_q[rs1];
    assign rs2Busy       = (rs2 != 5'd0) && pending_q[rs2];
    assign writeRegister = write_q;
    assign rd            = rd_q;
    assign dataToWrite   = data_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed-vector bench for register_writeback with hand-computed expectations.
module tb_register_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        loadIssue;
    logic [4:0]  loadIssueRd;
    logic        loadValid;
    logic [4:0]  loadRd;
    logic [31:0] loadData;
    logic        loadReady;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1Busy;
    logic        rs2Busy;
    logic        writeRegister;
    logic [4:0]  rd;
    logic [31:0] dataToWrite;

    int errors = 0;
    int checks = 0;

    register_writeback #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData),
        .loadIssue(loadIssue), .loadIssueRd(loadIssueRd),
        .loadValid(loadValid), .loadRd(loadRd), .loadData(loadData),
        .loadReady(loadReady),
        .rs1(rs1), .rs2(rs2), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .writeRegister(writeRegister), .rd(rd), .dataToWrite(dataToWrite)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        aluValid = 1'b0; aluRd = 5'd0; aluData = 32'd0;
        loadIssue = 1'b0; loadIssueRd = 5'd0;
        loadValid = 1'b0; loadRd = 5'd0; loadData = 32'd0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_data);
        check_eq({tag, "_we"}, 32'(writeRegister), 32'd1);
        check_eq({tag, "_rd"}, 32'(rd), 32'(exp_rd));
        check_eq({tag, "_data"}, dataToWrite, exp_data);
    endtask

    initial begin
        int accepted;
        logic acc;

        idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_we", 32'(writeRegister), 32'd0);
        check_eq("rst_rd", 32'(rd), 32'd0);
        check_eq("rst_data", dataToWrite, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(loadReady), 32'd1);

        // ALU writeback, then idle holds rd/data
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
        tick();
        idle_inputs();
        check_write("alu5", 5'd5, 32'hDEADBEEF);
        tick();
        check_eq("idle_we", 32'(writeRegister), 32'd0);
        check_eq("idle_rd_hold", 32'(rd), 32'd5);
        check_eq("idle_data_hold", dataToWrite, 32'hDEADBEEF);

        // Load issue / scoreboard / load writeback
        rs1 = 5'd7; rs2 = 5'd7;
        loadIssue = 1'b1; loadIssueRd = 5'd7;
        #1;
        check_eq("no_bypass_rs1", 32'(rs1Busy), 32'd0);
        tick();
        idle_inputs();
        check_eq("issue7_rs1", 32'(rs1Busy), 32'd1);
        check_eq("issue7_rs2", 32'(rs2Busy), 32'd1);
        loadValid = 1'b1; loadRd = 5'd7; loadData = 32'h12;
        tick();
        idle_inputs();
        check_eq("ld7_not_yet", 32'(writeRegister), 32'd0);
        check_eq("ld7_busy_until_pop", 32'(rs1Busy), 32'd1);
        tick();
        check_write("ld7", 5'd7, 32'h12);
        check_eq("ld7_cleared", 32'(rs1Busy), 32'd0);
        tick();
        check_eq("ld7_idle", 32'(writeRegister), 32'd0);

        // ALU starvation fills the buffer; loads then drain in order
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            aluValid = 1'b1; aluRd = 5'(10 + i); aluData = 32'h100 + 32'(i);
            loadValid = 1'b1; loadRd = 5'(20 + accepted); loadData = 32'hA0 + 32'(accepted);
            #1;
            acc = loadReady;
            tick();
            if (acc) accepted++;
            check_write($sformatf("starve_alu%0d", i), 5'(10 + i), 32'h100 + 32'(i));
        end
        idle_inputs();
        check_eq("starve_accepted", 32'(accepted), 32'd4);
        check_eq("starve_full_ready", 32'(loadReady), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_write($sformatf("drain%0d", k), 5'(20 + k), 32'hA0 + 32'(k));
        end
        tick();
        check_eq("drain_done_we", 32'(writeRegister), 32'd0);
        check_eq("drain_done_ready", 32'(loadReady), 32'd1);

        // Issue and pop of the same register in one cycle: set wins
        rs1 = 5'd9;
        loadIssue = 1'b1; loadIssueRd = 5'd9;
        tick();
        idle_inputs();
        loadValid = 1'b1; loadRd = 5'd9; loadData = 32'h99;
        tick();
        idle_inputs();
        loadIssue = 1'b1; loadIssueRd = 5'd9;
        tick();
        idle_inputs();
        check_write("ld9", 5'd9, 32'h99);
        check_eq("ld9_set_wins", 32'(rs1Busy), 32'd1);
        loadValid = 1'b1; loadRd = 5'd9; loadData = 32'h98;
        tick();
        idle_inputs();
        tick();
        check_write("ld9b", 5'd9, 32'h98);
        check_eq("ld9b_cleared", 32'(rs1Busy), 32'd0);

        // Register zero: no writes, never busy
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h55;
        tick();
        idle_inputs();
        check_eq("alu0_we", 32'(writeRegister), 32'd0);
        loadValid = 1'b1; loadRd = 5'd0; loadData = 32'h66;
        tick();
        idle_inputs();
        tick();
        check_eq("ld0_we", 32'(writeRegister), 32'd0);
        tick();
        check_eq("ld0_popped_ready", 32'(loadReady), 32'd1);
        rs1 = 5'd0;
        loadIssue = 1'b1; loadIssueRd = 5'd0;
        tick();
        idle_inputs();
        check_eq("issue0_rs1", 32'(rs1Busy), 32'd0);

        // Reset mid-operation with buffered entries and pending bits
        rs1 = 5'd3; rs2 = 5'd4;
        loadIssue = 1'b1; loadIssueRd = 5'd3;
        tick();
        loadIssueRd = 5'd4;
        tick();
        idle_inputs();
        check_eq("pre_rst_rs1", 32'(rs1Busy), 32'd1);
        check_eq("pre_rst_rs2", 32'(rs2Busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            aluValid = 1'b1; aluRd = 5'd1; aluData = 32'h200 + 32'(i);
            loadValid = 1'b1; loadRd = 5'(3 + i); loadData = 32'hB0 + 32'(i);
            tick();
        end
        reset = 1'b1;
        aluValid = 1'b1; aluRd = 5'd2; aluData = 32'h333;
        loadValid = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        check_eq("mid_rst_we", 32'(writeRegister), 32'd0);
        check_eq("mid_rst_rd", 32'(rd), 32'd0);
        check_eq("mid_rst_data", dataToWrite, 32'd0);
        check_eq("mid_rst_ready", 32'(loadReady), 32'd1);
        check_eq("mid_rst_rs1", 32'(rs1Busy), 32'd0);
        check_eq("mid_rst_rs2", 32'(rs2Busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("post_rst_nowrite%0d", k), 32'(writeRegister), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
